mips_pc_sequencer: RTL

- Program-counter controller for the Harvard MIPS core. Owns `instr_address`.
- Sequences fetch from the reset vector and applies branch/jump redirects with the MIPS one-instruction delay slot.
- Signals halt through `active` when execution reaches address 0x00000000.
- Sits between the decode/branch-compare logic and the instruction memory port.

---
 rtl/mips_pc_sequencer_if.sv | 36 +++
 rtl/mips_pc_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/mips_pc_sequencer_if.sv
// Fetch-control bus between the decode/branch-compare logic and the PC sequencer.
// Decode drives the advance controls and redirect requests. The sequencer returns the fetch state.
interface mips_pc_sequencer_if;
  logic        clk_enable;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump_imm;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] rs_value;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        in_delay_slot;
  logic        active;
  logic        addr_fault;
  logic [1:0]  state;

  // Redirect request semantics (no valid/ready pair):
  // - The redirect inputs are combinational decode of the instruction at instr_address.
  // - They are consumed only on an advance edge: clk_enable=1, stall=0 and the sequencer not halted.
  // - While they are not consumed they carry no obligation.
  // - They are ignored while in_delay_slot=1.
  modport master (
    output clk_enable, stall, branch_valid, branch_taken, branch_imm,
           jump_imm, jump_index, jump_reg, rs_value,
    input  instr_address, link_address, in_delay_slot, active, addr_fault, state
  );

  modport slave (
    input  clk_enable, stall, branch_valid, branch_taken, branch_imm,
           jump_imm, jump_index, jump_reg, rs_value,
    output instr_address, link_address, in_delay_slot, active, addr_fault, state
  );
endinterface

// File: rtl/mips_pc_sequencer.sv
// MIPS program-counter sequencer: reset-vector fetch, delayed branch/jump redirects,
// halt on reaching HALT_ADDR, and a sticky fault for misaligned jr/jalr targets.
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic            clk,
  input logic            reset,
  mips_pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DELAY = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        active;
  logic        in_delay_slot;
  logic        addr_fault;

  logic        advance;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  assign advance       = bus.clk_enable && !bus.stall && (state != S_HALT);
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
  assign jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign redirect      = bus.jump_reg || bus.jump_imm || (bus.branch_valid && bus.branch_taken);

  always_comb begin
    redirect_target = branch_target;
    if (bus.jump_reg)      redirect_target = bus.rs_value;
    else if (bus.jump_imm) redirect_target = jump_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      pc            <= RESET_VECTOR;
      target        <= '0;
      active        <= 1'b1;
      in_delay_slot <= 1'b0;
      addr_fault    <= 1'b0;
    end else if (advance) begin
      case (state)
        S_RUN: begin
          // active stays high through the first cycle at HALT_ADDR; this edge ends it
          if (pc == HALT_ADDR) begin
            active <= 1'b0;
            state  <= S_HALT;
          end else begin
            pc <= pc_plus4;
            if (redirect) begin
              target        <= redirect_target;
              in_delay_slot <= 1'b1;
              state         <= S_DELAY;
              if (redirect_target[1:0] != 2'b00) addr_fault <= 1'b1;
            end
          end
        end
        S_DELAY: begin
          in_delay_slot <= 1'b0;
          // A misaligned target is never fetched; PC stays on the delay slot
          if (target[1:0] != 2'b00) begin
            active <= 1'b0;
            state  <= S_HALT;
          end else begin
            pc    <= target;
            state <= S_RUN;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign bus.instr_address = pc;
  assign bus.link_address  = pc + 32'd8;
  assign bus.in_delay_slot = in_delay_slot;
  assign bus.active        = active;
  assign bus.addr_fault    = addr_fault;
  assign bus.state         = state;

endmodule
